// File: rtl/ethrxsched_if.sv
// Receive-scheduler bus: receiver handshake plus host-side frame queue head.
// master = scheduler side, slave = receiver/host side.
interface ethrxsched_if;
   logic        rxrdy;
   logic [10:0] rxcntb;
   logic        err_gen;
   logic        err_crc;
   logic        rxena;
   logic        rxdone;
   logic        rxbank;
   logic        hrdy;
   logic        hbank;
   logic [10:0] hlen;
   logic [2:0]  hstat;
   logic        hack;

   modport master (
      input  rxrdy, rxcntb, err_gen, err_crc, hack,
      output rxena, rxdone, rxbank, hrdy, hbank, hlen, hstat
   );

   modport slave (
      output rxrdy, rxcntb, err_gen, err_crc, hack,
      input  rxena, rxdone, rxbank, hrdy, hbank, hlen, hstat
   );
endinterface

// File: rtl/ethrxsched.sv
// Two-bank receive scheduler: arms the receiver, captures frames, queues them for the host.
// Optional RXDROPERR_EN: errored frames are acknowledged but discarded, their bank reused.
module ethrxsched #(
   parameter logic [10:0] MINLEN = 11'd60,
   parameter int unsigned MISSW  = 8
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             renable,
   input  logic             rxdv,
   input  logic             mclr,
   ethrxsched_if.master     bus,
   output logic [MISSW-1:0] missed
);

   typedef enum logic {StArm, StAck} state_t;

   state_t            state_q, state_d;
   logic              wbank_q, wbank_d;
   logic              hbank_q, hbank_d;
   logic [1:0]        full_q, full_d;
   logic [1:0][10:0]  len_q, len_d;
   logic [1:0][2:0]   stat_q, stat_d;
   logic              keep_q, keep_d;
   logic              rxena_q, rxena_d;
   logic              rxdone_q, rxdone_d;
   logic              rxdv_q;
   logic [MISSW-1:0]  missed_q, missed_d;
   logic              store;
   logic              frame_err;

   always_comb begin
      state_d   = state_q;
      wbank_d   = wbank_q;
      hbank_d   = hbank_q;
      full_d    = full_q;
      len_d     = len_q;
      stat_d    = stat_q;
      keep_d    = keep_q;
      missed_d  = missed_q;
      frame_err = bus.err_gen | bus.err_crc;
`ifdef RXDROPERR_EN
      store     = ~full_q[wbank_q] & ~frame_err;
`else
      store     = ~full_q[wbank_q];
`endif

      // hack only ever frees hbank; a capture in the same cycle targets the other bank
      if (bus.hack && full_q[hbank_q]) begin
         full_d[hbank_q] = 1'b0;
         hbank_d         = ~hbank_q;
      end

      unique case (state_q)
         StArm: begin
            if (bus.rxrdy) begin
               state_d = StAck;
               keep_d  = store;
               if (store) begin
                  full_d[wbank_q] = 1'b1;
                  len_d[wbank_q]  = bus.rxcntb;
                  stat_d[wbank_q] = {bus.rxcntb < MINLEN, bus.err_gen, bus.err_crc};
               end
            end
         end
         StAck: begin
            if (!bus.rxrdy) begin
               state_d = StArm;
               // a dropped frame leaves the write bank in place for reuse
               if (keep_q) wbank_d = ~wbank_q;
            end
         end
         default: state_d = StArm;
      endcase

      rxena_d  = (state_d == StArm) & renable & ~full_d[wbank_d];
      rxdone_d = (state_d == StAck);

      if (mclr) begin
         missed_d = '0;
      end else if ((&full_q) && rxdv && !rxdv_q && !(&missed_q)) begin
         missed_d = missed_q + {{(MISSW-1){1'b0}}, 1'b1};
      end
   end

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state_q  <= StArm;
         wbank_q  <= 1'b0;
         hbank_q  <= 1'b0;
         full_q   <= '0;
         len_q    <= '0;
         stat_q   <= '0;
         keep_q   <= 1'b0;
         rxena_q  <= 1'b0;
         rxdone_q <= 1'b0;
         rxdv_q   <= 1'b0;
         missed_q <= '0;
      end else begin
         state_q  <= state_d;
         wbank_q  <= wbank_d;
         hbank_q  <= hbank_d;
         full_q   <= full_d;
         len_q    <= len_d;
         stat_q   <= stat_d;
         keep_q   <= keep_d;
         rxena_q  <= rxena_d;
         rxdone_q <= rxdone_d;
         rxdv_q   <= rxdv;
         missed_q <= missed_d;
      end
   end

   assign bus.rxena  = rxena_q;
   assign bus.rxdone = rxdone_q;
   assign bus.rxbank = wbank_q;
   assign bus.hrdy   = full_q[hbank_q];
   assign bus.hbank  = hbank_q;
   assign bus.hlen   = len_q[hbank_q];
   assign bus.hstat  = stat_q[hbank_q];
   assign missed     = missed_q;

endmodule

// File: tb/tb_ethrxsched.sv
// Directed bench for ethrxsched: queue-based frame model checked every cycle,
// plus literal expectations for the documented scenarios.
module tb_ethrxsched;

   logic       clk = 1'b0;
   logic       clr;
   logic       renable;
   logic       rxdv;
   logic       mclr;
   logic [7:0] missed;

   ethrxsched_if bus ();

   ethrxsched dut (
      .clk     (clk),
      .clr     (clr),
      .renable (renable),
      .rxdv    (rxdv),
      .mclr    (mclr),
      .bus     (bus),
      .missed  (missed)
   );

   always #5 clk = ~clk;

   int ntest = 0;
   int nfail = 0;

   task automatic check(input string name, input int act, input int exp);
      ntest++;
      if (act != exp) begin
         nfail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Model: frames in flight are an ordered queue of at most two entries.
   typedef struct {
      logic [10:0] len;
      logic [2:0]  stat;
   } frm_t;

   frm_t mq[$];
   bit   m_h, m_w, m_inack, m_keep, m_rxdv, m_rxena;
   int   m_missed;

   always @(posedge clk or posedge clr) begin : model
      int   nb;
      frm_t f;
      if (clr) begin
         mq.delete();
         m_h = 0; m_w = 0; m_inack = 0; m_keep = 0;
         m_rxdv = 0; m_rxena = 0; m_missed = 0;
      end else begin
         nb = mq.size();
         if (mclr) m_missed = 0;
         else if (rxdv && !m_rxdv && nb == 2 && m_missed < 255) m_missed++;
         m_rxdv = rxdv;
         if (bus.hack && nb > 0) begin
            mq.delete(0);
            m_h = !m_h;
         end
         if (!m_inack) begin
            if (bus.rxrdy) begin
               m_inack = 1;
               m_keep  = (nb < 2);
`ifdef RXDROPERR_EN
               if (bus.err_gen || bus.err_crc) m_keep = 0;
`endif
               if (m_keep) begin
                  f.len  = bus.rxcntb;
                  f.stat = {(bus.rxcntb < 11'd60), bus.err_gen, bus.err_crc};
                  mq.push_back(f);
               end
            end
         end else if (!bus.rxrdy) begin
            m_inack = 0;
            if (m_keep) m_w = !m_w;
         end
         m_rxena = !m_inack && renable && (mq.size() < 2);
      end
   end

   always @(negedge clk) begin
      if (!clr) begin
         check("rxena",  int'(bus.rxena),  int'(m_rxena));
         check("rxdone", int'(bus.rxdone), int'(m_inack));
         check("rxbank", int'(bus.rxbank), int'(m_w));
         check("hbank",  int'(bus.hbank),  int'(m_h));
         check("hrdy",   int'(bus.hrdy),   int'(mq.size() > 0));
         check("missed", int'(missed),     m_missed);
         if (mq.size() > 0) begin
            check("hlen",  int'(bus.hlen),  int'(mq[0].len));
            check("hstat", int'(bus.hstat), int'(mq[0].stat));
         end
      end
   end

   task automatic do_reset();
      clr = 1'b1;
      renable = 1'b1; rxdv = 1'b0; mclr = 1'b0;
      bus.rxrdy = 1'b0; bus.rxcntb = '0; bus.err_gen = 1'b0; bus.err_crc = 1'b0;
      bus.hack = 1'b0;
      repeat (2) @(negedge clk);
      clr = 1'b0;
      @(negedge clk);
   endtask

   // Returns at a negedge with the scheduler back in ARM; lat = cycles to rxdone.
   task automatic send_frame(input logic [10:0] len, input logic g, input logic c,
                             output int lat);
      lat = 0;
      bus.rxcntb = len; bus.err_gen = g; bus.err_crc = c; bus.rxrdy = 1'b1;
      do begin
         @(negedge clk);
         lat++;
      end while (!bus.rxdone && lat < 20);
      if (!bus.rxdone) check("rxdone_timeout", 0, 1);
      bus.rxrdy = 1'b0; bus.err_gen = 1'b0; bus.err_crc = 1'b0;
      @(negedge clk);
   endtask

   task automatic pulse_hack();
      bus.hack = 1'b1;
      @(negedge clk);
      bus.hack = 1'b0;
   endtask

   task automatic rxdv_edge();
      rxdv = 1'b1;
      @(negedge clk);
      rxdv = 1'b0;
      @(negedge clk);
   endtask

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int lat;
      do_reset();
      check("reset_hrdy",   int'(bus.hrdy),   0);
      check("reset_rxbank", int'(bus.rxbank), 0);
      check("reset_missed", int'(missed),     0);
      check("reset_rxena",  int'(bus.rxena),  1);

      // 1: single good frame
      send_frame(11'd64, 1'b0, 1'b0, lat);
      check("t1_latency", lat, 1);
      check("t1_hrdy",   int'(bus.hrdy),   1);
      check("t1_hbank",  int'(bus.hbank),  0);
      check("t1_hlen",   int'(bus.hlen),   64);
      check("t1_hstat",  int'(bus.hstat),  0);
      check("t1_rxbank", int'(bus.rxbank), 1);

      // 2: both banks full, missed frame, host frees one
      do_reset();
      send_frame(11'd100, 1'b0, 1'b0, lat);
      send_frame(11'd200, 1'b0, 1'b0, lat);
      check("t2_rxena_full", int'(bus.rxena), 0);
      rxdv_edge();
      check("t2_missed", int'(missed), 1);
      pulse_hack();
      check("t2_hbank",  int'(bus.hbank),  1);
      check("t2_hlen",   int'(bus.hlen),   200);
      check("t2_rxena",  int'(bus.rxena),  1);
      check("t2_rxbank", int'(bus.rxbank), 0);

      // 3: runt and CRC-error frames
      do_reset();
      send_frame(11'd40, 1'b0, 1'b0, lat);
      check("t3_runt", int'(bus.hstat), 3'b100);
      send_frame(11'd80, 1'b0, 1'b1, lat);
`ifdef RXDROPERR_EN
      check("t3_drop_rxbank", int'(bus.rxbank), 1);
      pulse_hack();
      check("t3_drop_hrdy", int'(bus.hrdy), 0);
`else
      check("t3_rxbank", int'(bus.rxbank), 0);
      pulse_hack();
      check("t3_crc_hstat", int'(bus.hstat), 3'b001);
      check("t3_crc_hlen",  int'(bus.hlen),  80);
`endif

      // 4: missed counter saturation and mclr priority
      do_reset();
      send_frame(11'd100, 1'b0, 1'b0, lat);
      send_frame(11'd200, 1'b0, 1'b0, lat);
      for (int i = 0; i < 300; i++) rxdv_edge();
      check("t4_saturate", int'(missed), 255);
      rxdv = 1'b1; mclr = 1'b1;
      @(negedge clk);
      rxdv = 1'b0; mclr = 1'b0;
      @(negedge clk);
      check("t4_mclr", int'(missed), 0);

      // 5: stray hack, then hack coincident with capture
      do_reset();
      pulse_hack();
      check("t5_stray_hrdy",  int'(bus.hrdy),  0);
      check("t5_stray_hbank", int'(bus.hbank), 0);
      send_frame(11'd50, 1'b0, 1'b0, lat);
      bus.rxcntb = 11'd70; bus.rxrdy = 1'b1; bus.hack = 1'b1;
      @(negedge clk);
      bus.hack = 1'b0;
      check("t5_co_hrdy",  int'(bus.hrdy),   1);
      check("t5_co_hbank", int'(bus.hbank),  1);
      check("t5_co_hlen",  int'(bus.hlen),   70);
      check("t5_co_done",  int'(bus.rxdone), 1);
      bus.rxrdy = 1'b0;
      @(negedge clk);

      // 6: clr while in ACK with both banks full
      do_reset();
      send_frame(11'd100, 1'b0, 1'b0, lat);
      bus.rxcntb = 11'd200; bus.rxrdy = 1'b1;
      @(negedge clk);
      rxdv_edge();
      check("t6_pre_missed", int'(missed), 1);
      clr = 1'b1;
      #1;
      check("t6_clr_rxena",  int'(bus.rxena),  0);
      check("t6_clr_rxdone", int'(bus.rxdone), 0);
      check("t6_clr_rxbank", int'(bus.rxbank), 0);
      check("t6_clr_hrdy",   int'(bus.hrdy),   0);
      check("t6_clr_hbank",  int'(bus.hbank),  0);
      check("t6_clr_hlen",   int'(bus.hlen),   0);
      check("t6_clr_hstat",  int'(bus.hstat),  0);
      check("t6_clr_missed", int'(missed),     0);
      bus.rxrdy = 1'b0;
      @(negedge clk);
      clr = 1'b0;
      @(negedge clk);
      check("t6_rxena_after", int'(bus.rxena), 1);

      // renable drop mid-frame: frame still captured, nothing re-armed
      renable = 1'b0;
      send_frame(11'd90, 1'b0, 1'b0, lat);
      check("t7_hlen",  int'(bus.hlen),  90);
      check("t7_rxena", int'(bus.rxena), 0);

      $display("[TB] %0d tests run, %0d failed", ntest, nfail);
      $finish;
   end

endmodule
